// File: rtl/axis_frame_capture.sv
// rtl/axis_frame_capture.sv - AXI-Stream frame capture sink with AHB-Lite readback
//
// Captures one frame of stream samples into an internal buffer after software
// arms it, optionally waiting for a tuser start marker. Capture stops on tlast
// or when the buffer fills. Software reads control/status/count and the buffer
// over a zero-wait-state AHB-Lite slave.
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   ce                  clock enable for the stream side (AHB unaffected)
//   tdata_s .. tuser_s  AXI-Stream slave (sample, valid, ready, last, start marker)
//   haddr_s .. hsel_s   AHB-Lite slave request
//   hrdata_s            AHB read data (holds between reads)
//   hreadyout_s, hresp_s  tied to ready / OKAY
//   irq                 level done interrupt (done & IRQ_EN, registered)
module axis_frame_capture #(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          ce,
  input  logic [DW-1:0] tdata_s,
  input  logic          tvalid_s,
  output logic          tready_s,
  input  logic          tlast_s,
  input  logic          tuser_s,
  input  logic [31:0]   haddr_s,
  input  logic [1:0]    htrans_s,
  input  logic          hwrite_s,
  input  logic [2:0]    hsize_s,
  input  logic [31:0]   hwdata_s,
  input  logic          hsel_s,
  output logic [31:0]   hrdata_s,
  output logic          hreadyout_s,
  output logic          hresp_s,
  output logic          irq
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SYNC, S_CAPTURE, S_DONE} state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  state_t      state;
  logic        irq_en;
  logic        sync_en;
  logic        done;
  logic        ovf;
  logic        ready_q;
  logic [AW:0] count;

  logic [31:0] mem [DEPTH];

  logic        ap_valid;
  logic        ap_write;
  logic [9:0]  ap_addr;

  logic        ahb_valid;
  logic        wr_ctrl;
  logic        wr_status;
  logic        arm;
  logic        beat;
  logic        busy;
  logic        mem_we;
  logic        buf_hit;
  logic [31:0] tdata_ext;
  logic [31:0] rd_data;

  // Only word accesses are decoded; the remaining request bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{haddr_s[31:12], haddr_s[1:0], htrans_s[0], hsize_s, hwdata_s[31:3]};

  assign hreadyout_s = 1'b1;
  assign hresp_s     = 1'b0;

  assign ahb_valid = hsel_s & htrans_s[1];
  assign wr_ctrl   = ap_valid & ap_write & (ap_addr == 10'h000);
  assign wr_status = ap_valid & ap_write & (ap_addr == 10'h001);
  assign arm       = wr_ctrl & hwdata_s[0];

  // Upstream is never stalled while enabled: every state accepts beats,
  // IDLE/DONE simply drop them. ready_q keeps tready low through reset.
  assign tready_s = ready_q & ce;

  // An ARM write in the same cycle as a beat takes priority; the beat is lost.
  assign beat = tvalid_s & tready_s & ~arm;
  assign busy = (state == S_WAIT_SYNC) || (state == S_CAPTURE);

  // In WAIT_SYNC count is 0 after ARM, so count is the write index in both states.
  assign mem_we = beat & (((state == S_WAIT_SYNC) & tuser_s) | (state == S_CAPTURE));

  always_comb begin
    tdata_ext = '0;
    tdata_ext[DW-1:0] = tdata_s;
  end

  assign buf_hit = (haddr_s[11:10] == 2'b01) && ({1'b0, haddr_s[9:2]} < 9'(DEPTH));

  // Read data is selected with the address-phase address and registered,
  // so it is presented during the data phase.
  always_comb begin
    rd_data = '0;
    if (haddr_s[11:2] == 10'h000)
      rd_data = {29'd0, sync_en, irq_en, 1'b0};
    else if (haddr_s[11:2] == 10'h001)
      rd_data = {29'd0, ovf, done, busy};
    else if (haddr_s[11:2] == 10'h002)
      rd_data = 32'(count);
    else if (buf_hit)
      rd_data = mem[haddr_s[AW+1:2]];
  end

  // Buffer storage is not reset. A same-cycle AHB read sees the old word.
  always_ff @(posedge aclk) begin
    if (mem_we)
      mem[count[AW-1:0]] <= tdata_ext;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= S_IDLE;
      irq_en   <= 1'b0;
      sync_en  <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      count    <= '0;
      irq      <= 1'b0;
      ready_q  <= 1'b0;
      ap_valid <= 1'b0;
      ap_write <= 1'b0;
      ap_addr  <= '0;
      hrdata_s <= '0;
    end else begin
      ready_q  <= 1'b1;
      irq      <= done & irq_en;
      ap_valid <= ahb_valid;
      ap_write <= hwrite_s;
      ap_addr  <= haddr_s[11:2];

      if (ahb_valid && !hwrite_s)
        hrdata_s <= rd_data;

      if (wr_ctrl) begin
        irq_en  <= hwdata_s[1];
        sync_en <= hwdata_s[2];
      end

      // W1C clears come first so a same-cycle set below wins.
      if (wr_status) begin
        if (hwdata_s[1]) done <= 1'b0;
        if (hwdata_s[2]) ovf  <= 1'b0;
      end

      if (arm) begin
        count <= '0;
        done  <= 1'b0;
        ovf   <= 1'b0;
        state <= hwdata_s[2] ? S_WAIT_SYNC : S_CAPTURE;
      end else begin
        case (state)
          S_WAIT_SYNC: begin
            if (beat && tuser_s) begin
              count <= (AW+1)'(1);
              if (tlast_s) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_CAPTURE;
              end
            end
          end
          S_CAPTURE: begin
            if (beat) begin
              count <= count + 1'b1;
              if (tlast_s) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else if (count == LAST_IDX) begin
                state <= S_DONE;
                done  <= 1'b1;
                ovf   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_capture.sv
// tb/tb_axis_frame_capture.sv - self-checking bench for axis_frame_capture
module tb_axis_frame_capture;

  localparam int DEPTH = 256;

  logic        aclk = 1'b0;
  logic        areset;
  logic        ce;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hsel;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Accepted beats since the last ARM, as seen by the bench.
  logic [31:0] acc_d[$];
  bit          acc_l[$];
  bit          acc_u[$];
  logic [31:0] exp_q[$];

  axis_frame_capture #(.DW(32), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset), .ce(ce),
    .tdata_s(tdata), .tvalid_s(tvalid), .tready_s(tready), .tlast_s(tlast), .tuser_s(tuser),
    .haddr_s(haddr), .htrans_s(htrans), .hwrite_s(hwrite), .hsize_s(hsize),
    .hwdata_s(hwdata), .hsel_s(hsel), .hrdata_s(hrdata),
    .hreadyout_s(hreadyout), .hresp_s(hresp), .irq(irq)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_acc();
    acc_d.delete();
    acc_l.delete();
    acc_u.delete();
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
    @(posedge aclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    @(posedge aclk); #1;
    hwdata = '0;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
    @(posedge aclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    d = hrdata;
    check("hreadyout", {31'd0, hreadyout}, 32'd1);
    check("hresp", {31'd0, hresp}, 32'd0);
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    ahb_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last, input bit user);
    int  n;
    logic a;
    n = 0;
    tdata = d; tlast = last; tuser = user; tvalid = 1'b1;
    do begin
      @(negedge aclk);
      a = tready;
      n++;
      @(posedge aclk); #1;
    end while (a !== 1'b1 && n < 100);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    check("beat_accepted", {31'd0, a}, 32'd1);
    if (a === 1'b1) begin
      acc_d.push_back(d);
      acc_l.push_back(last);
      acc_u.push_back(user);
    end
  endtask

  // Expected frame from the accepted-beat list: optionally skip to the first
  // tuser beat, then keep beats up to the first tlast, at most DEPTH of them.
  task automatic build_expect(input bit sync, output bit fin, output bit ov);
    bit started;
    started = !sync;
    fin = 1'b0;
    ov  = 1'b0;
    exp_q.delete();
    for (int i = 0; i < acc_d.size(); i++) begin
      if (fin) break;
      if (!started && acc_u[i]) started = 1'b1;
      if (started) begin
        exp_q.push_back(acc_d[i]);
        if (acc_l[i]) fin = 1'b1;
        else if (exp_q.size() == DEPTH) begin
          fin = 1'b1;
          ov  = 1'b1;
        end
      end
    end
  endtask

  task automatic verify_frame(input string tag, input bit sync);
    bit fin;
    bit ov;
    build_expect(sync, fin, ov);
    check({tag, "_count"}, dut_count_read(), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check_reg({tag, "_buf"}, 32'h400 + 32'(4 * i), exp_q[i]);
    check_reg({tag, "_status"}, 32'h004, {29'd0, ov, fin, !fin});
  endtask

  function automatic logic [31:0] dut_count_read();
    return 32'hx;
  endfunction

  initial begin
    logic [31:0] v;
    int   cyc;
    int   n_acc;
    bit   fin;

    areset = 1'b1; ce = 1'b1;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; hwdata = '0; hsel = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tready", {31'd0, tready}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    areset = 1'b0;
    @(posedge aclk); #1;
    check_reg("rst_status", 32'h004, 32'h0);
    check_reg("rst_count", 32'h008, 32'h0);
    check_reg("rst_ctrl", 32'h000, 32'h0);

    // Plain frame, tlast on the 5th beat, IRQ enabled.
    clear_acc();
    ahb_write(32'h000, 32'h3);
    check_reg("a_ctrl", 32'h000, 32'h2);
    for (int i = 0; i < 5; i++)
      send_beat(32'h11 + 32'(i), i == 4, 1'b0);
    check("a_irq_not_early", {31'd0, irq}, 32'd0);
    @(posedge aclk); #1;
    check("a_irq", {31'd0, irq}, 32'd1);
    ahb_read(32'h008, v);
    check("a_count", v, 32'd5);
    build_expect(1'b0, fin, fin);
    for (int i = 0; i < 5; i++)
      check_reg("a_buf", 32'h400 + 32'(4 * i), 32'h11 + 32'(i));
    check_reg("a_status", 32'h004, 32'h2);

    // Sync mode: beats before tuser are dropped.
    clear_acc();
    ahb_write(32'h000, 32'h7);
    check_reg("b_busy", 32'h004, 32'h1);
    for (int i = 0; i < 3; i++)
      send_beat($urandom, 1'b0, 1'b0);
    send_beat(32'hA0, 1'b0, 1'b1);
    send_beat(32'hA1, 1'b1, 1'b0);
    ahb_read(32'h008, v);
    check("b_count", v, 32'd2);
    check_reg("b_buf0", 32'h400, 32'hA0);
    check_reg("b_buf1", 32'h404, 32'hA1);
    check_reg("b_status", 32'h004, 32'h2);

    // Overflow: DEPTH+10 beats, no tlast.
    clear_acc();
    ahb_write(32'h000, 32'h3);
    for (int i = 0; i < DEPTH + 10; i++)
      send_beat($urandom, 1'b0, 1'($urandom));
    build_expect(1'b0, fin, fin);
    ahb_read(32'h008, v);
    check("c_count", v, 32'(DEPTH));
    for (int i = 0; i < exp_q.size(); i++)
      check_reg("c_buf", 32'h400 + 32'(4 * i), exp_q[i]);
    check_reg("c_status", 32'h004, 32'h6);
    check("c_irq", {31'd0, irq}, 32'd1);
    ahb_write(32'h004, 32'h6);
    check_reg("c_status_clr", 32'h004, 32'h0);
    @(posedge aclk); #1;
    check("c_irq_clr", {31'd0, irq}, 32'd0);

    // Random tvalid gaps and ce toggling; 20-beat frame.
    clear_acc();
    ahb_write(32'h000, 32'h3);
    n_acc = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 600) begin
      tvalid = ($urandom % 4) != 0;
      ce     = ($urandom % 4) != 0;
      tdata  = $urandom;
      tuser  = 1'($urandom);
      tlast  = (n_acc == 19);
      @(negedge aclk);
      check("d_tready_ce", {31'd0, tready}, {31'd0, ce});
      if (tvalid && ce) begin
        acc_d.push_back(tdata);
        acc_l.push_back(tlast);
        acc_u.push_back(tuser);
        n_acc++;
        if (tlast) fin = 1'b1;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; ce = 1'b1;
    check("d_finished", {31'd0, fin}, 32'd1);
    build_expect(1'b0, fin, fin);
    ahb_read(32'h008, v);
    check("d_count", v, 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check_reg("d_buf", 32'h400 + 32'(4 * i), exp_q[i]);
    check_reg("d_status", 32'h004, 32'h2);

    // Reset on the 4th beat of a capture, then capture again.
    clear_acc();
    ahb_write(32'h000, 32'h3);
    for (int i = 0; i < 3; i++)
      send_beat(32'h100 + 32'(i), 1'b0, 1'b0);
    tvalid = 1'b1; tdata = 32'h103; areset = 1'b1;
    #1;
    check("e_rst_tready", {31'd0, tready}, 32'd0);
    check("e_rst_irq", {31'd0, irq}, 32'd0);
    check("e_rst_hrdata", hrdata, 32'd0);
    @(posedge aclk); #1;
    tvalid = 1'b0;
    areset = 1'b0;
    check_reg("e_count", 32'h008, 32'h0);
    check_reg("e_status", 32'h004, 32'h0);
    check_reg("e_ctrl", 32'h000, 32'h0);
    clear_acc();
    ahb_write(32'h000, 32'h3);
    for (int i = 0; i < 4; i++)
      send_beat(32'h200 + 32'(i), i == 3, 1'b0);
    @(posedge aclk); #1;
    check("e_irq", {31'd0, irq}, 32'd1);
    build_expect(1'b0, fin, fin);
    ahb_read(32'h008, v);
    check("e_count2", v, 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check_reg("e_buf", 32'h400 + 32'(4 * i), exp_q[i]);
    check_reg("e_unmapped", 32'h00C, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_capture.md
Name: axis_frame_capture

Overview:
- AXI-Stream slave that terminates a sample stream and stores one frame of samples in an internal buffer. The frame is read back by software over an AHB-Lite slave port.
- It is the receiving end of the stream interface that the subsystem's AXIS sources drive. It sits downstream of the DSP subsystem as a debug/scope capture sink on the same AHB fabric.
- Arm, optional sync-on-tuser, stop-on-tlast or buffer-full, done interrupt.

Parameters:
- DW, 32, stream data width (1..32; stored zero-extended to 32 bits)
- DEPTH, 256, buffer depth in samples (power of two, 2..256)
- AW, $clog2(DEPTH), buffer address width (derived)

Ports:
- aclk  in  1  clock for both the stream and AHB sides
- areset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; when low, stream handshake and state are frozen, and AHB keeps responding
- tdata_s  in  DW  stream sample
- tvalid_s  in  1  stream valid
- tready_s  out  1  stream ready
- tlast_s  in  1  end of frame
- tuser_s  in  1  start-of-frame marker
- haddr_s  in  32  AHB address (only [11:2] are decoded)
- htrans_s  in  2  AHB transfer type
- hwrite_s  in  1  AHB write
- hsize_s  in  3  AHB size (only word accesses are supported; other sizes are treated as word)
- hwdata_s  in  32  AHB write data
- hsel_s  in  1  AHB select
- hrdata_s  out  32  AHB read data
- hreadyout_s  out  1  always 1 (zero wait state)
- hresp_s  out  1  always 0 (OKAY)
- irq  out  1  done interrupt, level

Behaviour:
- Reset: state IDLE; CTRL=0; COUNT=0; done=0; ovf=0; tready_s=0; hrdata_s=0; irq=0. Buffer contents are undefined.
- Register map (offset = haddr_s[11:0]):
  - 0x000 CTRL, RW: bit0 ARM (write-1 pulse, reads 0); bit1 IRQ_EN; bit2 SYNC (wait for tuser).
  - 0x004 STATUS: bit0 busy (RO); bit1 done (W1C); bit2 ovf (W1C; set when a frame hits DEPTH without tlast).
  - 0x008 COUNT, RO: samples stored, 0..DEPTH.
  - 0x400 + 4*i BUF[i], RO, i < DEPTH. Writes to the buffer window are ignored.
  - Unmapped addresses read 0.
- AHB:
  - A transfer is valid when hsel_s & htrans_s[1].
  - Address, write and valid are registered in the address phase; writes take effect at the end of the data phase using hwdata_s.
  - Buffer RAM is read with the address-phase address, so data appears on hrdata_s in the data phase. A read of a buffer location in the same cycle as a capture write to it returns the old data.
  - hrdata_s holds its last value when there is no read data phase.
- FSM: IDLE, WAIT_SYNC, CAPTURE, DONE.
  - IDLE / DONE: tready_s=1 and incoming beats are discarded, so upstream never stalls.
  - ARM write, from any state: COUNT←0, done←0, ovf←0; next state is WAIT_SYNC if SYNC=1, else CAPTURE.
  - WAIT_SYNC: tready_s=1; beats with tuser_s=0 are discarded. The first accepted beat with tuser_s=1 is stored at BUF[0] (COUNT←1) and the state moves to CAPTURE, or straight to DONE if tlast_s=1 on that beat.
  - CAPTURE: tready_s=1. Each accepted beat (tvalid_s & tready_s & ce) is written to BUF[COUNT], then COUNT←COUNT+1.
    - Accepted beat with tlast_s=1 → DONE.
    - Accepted beat with COUNT==DEPTH-1 and tlast_s=0 → DONE, ovf←1.
    - tlast_s and full on the same beat → DONE, ovf=0.
  - Entry to DONE sets done←1.
- busy = (state==WAIT_SYNC or CAPTURE).
- irq = done & IRQ_EN, registered; asserts 1 cycle after done is set.
- Simultaneous events:
  - W1C of done in the same cycle that done is set: set wins.
  - ARM in the same cycle as a capture beat: ARM wins and the beat is discarded.
- ce=0: no beats accepted (tready_s driven 0), FSM holds, and AHB register access still operates.
- Reset asserted mid-capture: returns immediately to the reset values above. No AHB response is pending after reset.

Test Plan:
- Reset, then read 0x004 and 0x008 → both 0; hreadyout_s=1; hresp_s=0 throughout.
- CTRL=0x2, ARM; send 5 beats 0x11..0x15 with tlast on the 5th → COUNT=5; BUF[0..4]=0x11..0x15; done=1; irq=1 one cycle after the last beat; ovf=0.
- CTRL=0x6, ARM; send 3 beats with tuser=0, then tuser=1 data 0xA0, then 0xA1 with tlast → COUNT=2; BUF[0]=0xA0; BUF[1]=0xA1.
- ARM; stream DEPTH+10 beats with no tlast → COUNT=256; done=1; ovf=1; extra beats dropped while tready_s stays 1; write 0x6 to 0x004 → done=0, ovf=0, irq=0.
- Random tvalid gaps and ce toggling during capture → stored sequence equals the accepted-beat sequence and tready_s=0 whenever ce=0.
- Assert areset on beat 3 of a capture → tready_s, irq and COUNT are 0 immediately; a new ARM captures normally afterwards.
